// File: rtl/gmm_model_port_scheduler.sv
// Pixel sequencer and single-port model memory arbiter for the GMM colour pipe.
// Issues model reads for incoming pixels, pairs returning data with pixels in a queue, and interleaves writebacks.
module gmm_model_port_scheduler #(
    parameter int unsigned ADDR_WIDTH   = 21,
    parameter int unsigned FRAME_PIXELS = 2073600,
    parameter int unsigned PIX_WIDTH    = 24,
    parameter int unsigned MODEL_WIDTH  = 120,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned WB_MAX_RUN   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [PIX_WIDTH-1:0]   pix_data,
    input  logic                   pix_sop,
    output logic                   pix_ready,
    input  logic                   init_req,
    input  logic                   wb_valid,
    input  logic [ADDR_WIDTH-1:0]  wb_addr,
    input  logic [MODEL_WIDTH-1:0] wb_data,
    output logic                   wb_ready,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [MODEL_WIDTH-1:0] mem_wdata,
    input  logic [MODEL_WIDTH-1:0] mem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIX_WIDTH-1:0]   out_pix,
    output logic [MODEL_WIDTH-1:0] out_model,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_init,
    output logic                   frame_done,
    output logic                   sync_err
);
    localparam int unsigned STAGES = RD_LATENCY + 1;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + STAGES + 1);
    localparam int unsigned RW     = $clog2(WB_MAX_RUN + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

    typedef struct packed {
        logic [PIX_WIDTH-1:0]   pix;
        logic [ADDR_WIDTH-1:0]  addr;
        logic                   init;
        logic [MODEL_WIDTH-1:0] model;
    } entry_t;

    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic                  credit_ok;
    logic                  rd_grant;
    logic                  wr_grant;
    logic [RW-1:0]         run;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  init_pending;
    logic                  init_active;
    logic                  pix_init;

    logic [STAGES-1:0]     st_valid;
    logic [STAGES-1:0]     st_init;
    logic [PIX_WIDTH-1:0]  st_pix  [STAGES];
    logic [ADDR_WIDTH-1:0] st_addr [STAGES];

    entry_t                fifo_mem [FIFO_DEPTH];
    entry_t                head;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            inflight = inflight + CW'(st_valid[i]);
        end
    end

    // Reads in flight hold a credit so every returning word has a guaranteed queue slot.
    assign credit_ok = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign wb_ready  = rst & wb_valid & ~((run == RW'(WB_MAX_RUN)) & pix_valid & credit_ok);
    assign pix_ready = rst & credit_ok & ~(wb_valid & wb_ready);
    assign rd_grant  = pix_valid & pix_ready;
    assign wr_grant  = wb_valid & wb_ready;
    assign pix_addr  = pix_sop ? '0 : cnt;
    assign pix_init  = init_active | (init_pending & (pix_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            run          <= '0;
            init_pending <= 1'b1;
            init_active  <= 1'b0;
            frame_done   <= 1'b0;
            sync_err     <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            st_valid     <= '0;
        end else begin
            mem_rd     <= rd_grant;
            mem_wr     <= wr_grant;
            mem_addr   <= wr_grant ? wb_addr : (rd_grant ? pix_addr : '0);
            mem_wdata  <= wr_grant ? wb_data : '0;
            frame_done <= rd_grant & (pix_addr == LAST_ADDR);
            sync_err   <= rd_grant & pix_sop & (cnt != '0);
            st_valid   <= {st_valid[STAGES-2:0], rd_grant};

            if (!pix_valid || rd_grant) begin
                run <= '0;
            end else if (wr_grant && run != RW'(WB_MAX_RUN)) begin
                run <= run + RW'(1);
            end

            if (rd_grant) begin
                cnt <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + ADDR_WIDTH'(1);
            end

            if (init_req) begin
                init_pending <= 1'b1;
            end else if (rd_grant && pix_addr == '0) begin
                init_pending <= 1'b0;
            end

            if (rd_grant && pix_addr == LAST_ADDR) begin
                init_active <= 1'b0;
            end else if (rd_grant && pix_addr == '0 && init_pending) begin
                init_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        st_pix[0]  <= pix_data;
        st_addr[0] <= pix_addr;
        st_init    <= {st_init[STAGES-2:0], pix_init};
        for (int unsigned i = 1; i < STAGES; i++) begin
            st_pix[i]  <= st_pix[i-1];
            st_addr[i] <= st_addr[i-1];
        end
    end

    assign push = st_valid[STAGES-1];
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pix: st_pix[STAGES-1], addr: st_addr[STAGES-1],
                                  init: st_init[STAGES-1], model: mem_rdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));

    // Head fields are masked while empty so the outputs read zero after reset.
    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_pix   = out_valid ? head.pix : '0;
    assign out_addr  = out_valid ? head.addr : '0;
    assign out_init  = out_valid & head.init;
    assign out_model = (out_valid && !head.init) ? head.model : '0;

endmodule

// File: tb/tb_gmm_model_port_scheduler.sv
// Self-checking bench for gmm_model_port_scheduler with a 16-pixel frame.
// Vector table plus hand sequences; a scoreboard queue holds expected pipe outputs.
module tb_gmm_model_port_scheduler;
    localparam int unsigned AW = 21;
    localparam int unsigned FP = 16;
    localparam int unsigned PW = 24;
    localparam int unsigned MW = 120;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = 8;
    localparam int unsigned WR = 4;
    localparam logic [AW-1:0] WB_ADDR = 21'h1ABCD;
    localparam logic [MW-1:0] WB_DATA = {8{15'h06B3}};

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_sop;
    logic          pix_ready;
    logic          init_req;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [MW-1:0] wb_data;
    logic          wb_ready;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;
    logic [MW-1:0] out_model;
    logic [AW-1:0] out_addr;
    logic          out_init;
    logic          frame_done;
    logic          sync_err;

    always #5 clk = ~clk;

    gmm_model_port_scheduler #(
        .ADDR_WIDTH(AW), .FRAME_PIXELS(FP), .PIX_WIDTH(PW), .MODEL_WIDTH(MW),
        .RD_LATENCY(RL), .FIFO_DEPTH(FD), .WB_MAX_RUN(WR)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sop(pix_sop), .pix_ready(pix_ready),
        .init_req(init_req),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_model(out_model),
        .out_addr(out_addr), .out_init(out_init), .frame_done(frame_done), .sync_err(sync_err)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [MW-1:0] pat(input logic [AW-1:0] a);
        return {a, ~a, a, ~a, a, 15'h1234};
    endfunction

    // Memory model: read data appears RL cycles after the registered mem_rd strobe.
    logic [MW-1:0] rpipe [RL];
    always @(posedge clk) begin
        rpipe[0] <= mem_rd ? pat(mem_addr) : '0;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RL-1];

    typedef struct {
        logic [PW-1:0] pix;
        logic [AW-1:0] addr;
        logic          init;
        logic [MW-1:0] model;
        int unsigned   acc;
        bit            lat;
    } sb_t;
    sb_t sb[$];

    int unsigned both_cnt = 0, fd_cnt = 0, fd_cyc = 0, se_cnt = 0, se_cyc = 0;
    bit          log_en = 1'b0;
    logic [1:0]  grant_log[$];
    bit          prev_stall = 1'b0;
    logic [191:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
            if (frame_done) begin fd_cnt <= fd_cnt + 1; fd_cyc <= cyc; end
            if (sync_err) begin se_cnt <= se_cnt + 1; se_cyc <= cyc; end
            if (log_en && (mem_rd || mem_wr)) grant_log.push_back({mem_rd, mem_wr});
            if (mem_wr) chk("mem_write", {mem_addr, mem_wdata}, {WB_ADDR, WB_DATA});
            if (prev_stall)
                chk("stall_hold", {out_valid, out_pix, out_addr, out_init, out_model}, held);
            prev_stall <= out_valid && !out_ready;
            held       <= {out_valid, out_pix, out_addr, out_init, out_model};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_out", $sformatf("got addr %0h pix %0h, required no output", out_addr, out_pix));
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("out_entry", {out_pix, out_addr, out_init, out_model},
                        {e.pix, e.addr, e.init, e.model});
                    if (e.lat) chk("latency", cyc - e.acc, RL + 2);
                end
            end
        end
    end

    int unsigned last_acc;

    task automatic send(input logic [PW-1:0] pix, input logic sop, input logic [AW-1:0] ea,
                        input logic ei, input bit lat, input int unsigned bound, output bit ok);
        sb_t e;
        pix_valid = 1'b1;
        pix_data  = pix;
        pix_sop   = sop;
        ok        = 1'b0;
        for (int unsigned c = 0; c < bound && !ok; c++) begin
            @(negedge clk);
            if (pix_ready) begin
                ok = 1'b1;
                last_acc = cyc;
                e = '{pix: pix, addr: ea, init: ei, model: ei ? '0 : pat(ea), acc: cyc, lat: lat};
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        pix_sop = 1'b0;
    endtask

    task automatic send_req(input logic [PW-1:0] pix, input logic sop, input logic [AW-1:0] ea,
                            input logic ei, input bit lat);
        bit ok;
        send(pix, sop, ea, ei, lat, 20, ok);
        if (!ok) fail_now("accept_timeout", $sformatf("pixel %0h not accepted in 20 cycles, required accept", pix));
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_sop   = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drain_left"}, sb.size(), 0);
    endtask

    typedef struct {
        logic [PW-1:0] pix;
        logic          sop;
        logic [AW-1:0] addr;
        logic          init;
        int unsigned   gap;
        bit            lat;
    } vec_t;
    vec_t vt [10];

    initial begin
        bit ok;
        int unsigned n_acc, acc15, acc_sop, mism;

        vt[0] = '{24'h100000, 1'b0, 21'd0,  1'b1, 8, 1'b1};
        vt[1] = '{24'h100001, 1'b0, 21'd1,  1'b1, 8, 1'b1};
        vt[2] = '{24'h100002, 1'b0, 21'd2,  1'b1, 8, 1'b1};
        vt[3] = '{24'h300011, 1'b0, 21'd11, 1'b1, 0, 1'b0};
        vt[4] = '{24'h300012, 1'b0, 21'd12, 1'b1, 0, 1'b0};
        vt[5] = '{24'h300013, 1'b0, 21'd13, 1'b1, 0, 1'b0};
        vt[6] = '{24'h300014, 1'b0, 21'd14, 1'b1, 0, 1'b0};
        vt[7] = '{24'h300015, 1'b0, 21'd15, 1'b1, 0, 1'b0};
        vt[8] = '{24'h300000, 1'b0, 21'd0,  1'b0, 0, 1'b0};
        vt[9] = '{24'h300001, 1'b0, 21'd1,  1'b0, 0, 1'b0};

        rst = 1'b0; pix_valid = 1'b1; pix_data = 24'hABCDEF; pix_sop = 1'b0; init_req = 1'b0;
        wb_valid = 1'b1; wb_addr = WB_ADDR; wb_data = WB_DATA; out_ready = 1'b1;
        acc15 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
        chk("rst_pulses", {frame_done, sync_err}, 0);
        chk("rst_out_fields", {out_pix, out_addr, out_init, out_model}, 0);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // First frame after reset: spaced pixels, exact latency, init frame.
        for (int i = 0; i < 3; i++) begin
            send_req(vt[i].pix, vt[i].sop, vt[i].addr, vt[i].init, vt[i].lat);
            idle();
            repeat (vt[i].gap) @(posedge clk);
            #1;
        end
        drain("basic");

        // Output stalled: exactly FD pixels accepted, then all emerge in order.
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            send(24'h200000 + 24'(i), 1'b0, AW'(3 + i), 1'b1, 1'b0, 20, ok);
            if (!ok) break;
            n_acc++;
        end
        chk("full_pix_ready", pix_ready, 0);
        idle();
        chk("full_accept_count", n_acc, FD);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("full");

        // Frame end and wrap; init clears after the first frame.
        for (int i = 3; i < 10; i++) begin
            send_req(vt[i].pix, vt[i].sop, vt[i].addr, vt[i].init, vt[i].lat);
            if (vt[i].addr == 21'd15) acc15 = last_acc;
        end
        idle();
        drain("wrap");
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_done_cyc", fd_cyc, acc15 + 1);

        // Continuous writebacks against continuous pixels: W W W W R repeating.
        log_en   = 1'b1;
        wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) send_req(24'h400000 + 24'(i), 1'b0, AW'(2 + i), 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        log_en = 1'b0;
        chk("wb_grant_count", grant_log.size(), 15);
        mism = 0;
        foreach (grant_log[k]) if (grant_log[k] !== ((k % 5 == 4) ? 2'b10 : 2'b01)) mism++;
        chk("wb_grant_pattern", mism, 0);
        drain("wb");

        // Resync at cnt=5 with a pending init request.
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        send_req(24'h500000, 1'b1, 21'd0, 1'b1, 1'b0);
        acc_sop = last_acc;
        send_req(24'h500001, 1'b0, 21'd1, 1'b1, 1'b0);
        idle();
        drain("sync");
        chk("sync_err_cnt", se_cnt, 1);
        chk("sync_err_cyc", se_cyc, acc_sop + 1);

        // Reset with 3 reads in flight and 4 entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_req(24'h600000 + 24'(i), 1'b0, AW'(2 + i), 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pix_ready", pix_ready, 0);
        sb.delete();
        idle();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_quiet", out_valid, 0);
        send_req(24'h700000, 1'b0, 21'd0, 1'b1, 1'b1);
        send_req(24'h700001, 1'b0, 21'd1, 1'b1, 1'b0);
        idle();
        drain("post_rst");
        chk("rd_wr_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
